// File: rtl/audio_i2s_tx_if.sv
// Stereo sample bus shared by the FX chain: one sample pair plus a one-cycle
// valid strobe. The producer drives through master; the consumer reads through slave.
interface audio_i2s_tx_if #(
    parameter int DATA_W = 16
);
    logic [1:0][DATA_W-1:0] audio_in;
    logic                   sample_en;

    modport master (
        output audio_in,
        output sample_en
    );

    modport slave (
        input audio_in,
        input sample_en
    );
endinterface

// File: rtl/audio_i2s_tx.sv
// Philips I2S stereo transmitter: buffers one sample pair and shifts it out
// MSB-first on a divided-down bit clock, flagging underrun and overrun.
module audio_i2s_tx #(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    audio_i2s_tx_if.slave       bus,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                frame_start,
    output logic                underrun,
    output logic                overrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BW    = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BW-1:0]    IDX_LAST = BW'(2 * SLOT_W - 1);
    localparam logic [BW-1:0]    SLOT_B   = BW'(SLOT_W);

    generate
        if (SLOT_W < DATA_W + 1 || BCLK_DIV < 1) begin : g_param_check
            $error("audio_i2s_tx: illegal parameters DATA_W=%0d SLOT_W=%0d BCLK_DIV=%0d",
                   DATA_W, SLOT_W, BCLK_DIV);
        end
    endgenerate

    logic [DIV_W-1:0]       div_cnt_reg, div_cnt_next;
    logic                   bclk_reg, bclk_next;
    logic [BW-1:0]          bit_idx_reg, bit_idx_next;
    logic                   lrclk_reg, lrclk_next;
    logic                   sdata_reg, sdata_next;
    logic [1:0][DATA_W-1:0] frame_reg, frame_next;
    logic [1:0][DATA_W-1:0] pending_reg, pending_next;
    logic                   pending_full_reg, pending_full_next;
    logic                   frame_start_reg, frame_start_next;
    logic                   underrun_reg, underrun_next;
    logic                   overrun_reg, overrun_next;

    logic                   div_wrap;
    logic                   fall_event;
    logic                   load;
    logic [BW-1:0]          idx_inc;
    logic [BW-1:0]          pos_inc;
    logic                   lr_inc;
    logic [DATA_W-1:0]      word;
    logic [DATA_W:1]        bit_hit;

    assign div_wrap   = (div_cnt_reg == DIV_LAST);
    assign fall_event = div_wrap & bclk_reg;
    assign load       = fall_event & (bit_idx_reg == IDX_LAST);

    // Position the serial state will take at the coming fall event.
    assign idx_inc = (bit_idx_reg == IDX_LAST) ? '0 : bit_idx_reg + 1'b1;
    assign lr_inc  = (idx_inc >= SLOT_B);
    assign pos_inc = lr_inc ? (idx_inc - SLOT_B) : idx_inc;
    assign word    = lr_inc ? frame_reg[1] : frame_reg[0];

    // Slot position p (1..DATA_W) carries word bit DATA_W-p; every other position is 0.
    generate
        for (genvar gi = 1; gi <= DATA_W; gi++) begin : g_bit_sel
            assign bit_hit[gi] = (pos_inc == BW'(gi)) & word[DATA_W-gi];
        end
    endgenerate

    always_comb begin
        div_cnt_next      = div_wrap ? '0 : div_cnt_reg + 1'b1;
        bclk_next         = div_wrap ? ~bclk_reg : bclk_reg;
        bit_idx_next      = bit_idx_reg;
        lrclk_next        = lrclk_reg;
        sdata_next        = sdata_reg;
        frame_next        = frame_reg;
        pending_next      = pending_reg;
        pending_full_next = pending_full_reg;
        frame_start_next  = 1'b0;
        underrun_next     = 1'b0;
        overrun_next      = 1'b0;

        if (fall_event) begin
            bit_idx_next = idx_inc;
            lrclk_next   = lr_inc;
            sdata_next   = |bit_hit;
        end

        if (load) begin
            frame_start_next = 1'b1;
            if (bus.sample_en) begin
                // A sample arriving on the load edge bypasses the buffer.
                frame_next        = bus.audio_in;
                pending_full_next = 1'b0;
            end else if (pending_full_reg) begin
                frame_next        = pending_reg;
                pending_full_next = 1'b0;
            end else begin
                underrun_next = 1'b1;
            end
        end else if (bus.sample_en) begin
            pending_next      = bus.audio_in;
            pending_full_next = 1'b1;
            overrun_next      = pending_full_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_reg      <= '0;
            bclk_reg         <= 1'b0;
            bit_idx_reg      <= IDX_LAST;
            lrclk_reg        <= 1'b0;
            sdata_reg        <= 1'b0;
            frame_reg        <= '0;
            pending_reg      <= '0;
            pending_full_reg <= 1'b0;
            frame_start_reg  <= 1'b0;
            underrun_reg     <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            div_cnt_reg      <= div_cnt_next;
            bclk_reg         <= bclk_next;
            bit_idx_reg      <= bit_idx_next;
            lrclk_reg        <= lrclk_next;
            sdata_reg        <= sdata_next;
            frame_reg        <= frame_next;
            pending_reg      <= pending_next;
            pending_full_reg <= pending_full_next;
            frame_start_reg  <= frame_start_next;
            underrun_reg     <= underrun_next;
            overrun_reg      <= overrun_next;
        end
    end

    assign i2s_bclk    = bclk_reg;
    assign i2s_lrclk   = lrclk_reg;
    assign i2s_sdata   = sdata_reg;
    assign frame_start = frame_start_reg;
    assign underrun    = underrun_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: per-cycle comparison against an arithmetic I2S
// reference plus decoded-frame checks for the directed scenarios.
module tb_audio_i2s_tx;

    localparam int DW    = 16;
    localparam int SW    = 32;
    localparam int DIV   = 2;
    localparam int DWB   = $clog2(DW);
    localparam int FRAME = 4 * SW * DIV;
    localparam logic [63:0] LR_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    audio_i2s_tx_if #(.DATA_W(DW)) bus();

    logic i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun;

    audio_i2s_tx #(
        .DATA_W   (DW),
        .SLOT_W   (SW),
        .BCLK_DIV (DIV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sdata   (i2s_sdata),
        .frame_start (frame_start),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    // Reference model state: n = clock edges since reset release.
    int                     n;
    logic [1:0][DW-1:0]     m_frame, m_pend;
    bit                     m_full;
    logic                   e_bclk, e_lr, e_sd, e_fs, e_ur, e_ov;
    int                     m_ur_cnt, m_ov_cnt, dut_ur_cnt, dut_ov_cnt;
    int                     stream_err, first_bad_n;
    logic [5:0]             first_got, first_exp;
    int                     vectors, miscompares;

    function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
        return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
    endfunction

    // Advance one clock, update the reference, and tally per-cycle disagreements.
    task automatic tick();
        int b, p;
        bit fall;
        logic [DW-1:0] w;
        b = -1;
        @(posedge clk);
        if (!reset_n) begin
            n = 0; m_full = 0; m_frame = '0; m_pend = '0;
            e_bclk = 0; e_lr = 0; e_sd = 0; e_fs = 0; e_ur = 0; e_ov = 0;
        end else begin
            n++;
            e_fs = 0; e_ur = 0; e_ov = 0;
            e_bclk = ((n / DIV) % 2) == 1;
            fall = (n % (2 * DIV)) == 0;
            if (fall) begin
                b = (n / (2 * DIV) - 1) % (2 * SW);
                if (b == 0) begin
                    e_fs = 1;
                    if (bus.sample_en) begin
                        m_frame = bus.audio_in; m_full = 0;
                    end else if (m_full) begin
                        m_frame = m_pend; m_full = 0;
                    end else begin
                        e_ur = 1; m_ur_cnt++;
                    end
                end
                e_lr = (b >= SW);
                p = b % SW;
                w = e_lr ? m_frame[1] : m_frame[0];
                e_sd = (p >= 1 && p <= DW) ? w[DWB'(DW - p)] : 1'b0;
            end
            if (b != 0 && bus.sample_en) begin
                if (m_full) begin
                    e_ov = 1; m_ov_cnt++;
                end
                m_pend = bus.audio_in;
                m_full = 1;
            end
        end
        #1;
        if ({i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun}
                !== {e_bclk, e_lr, e_sd, e_fs, e_ur, e_ov}) begin
            if (stream_err == 0) begin
                first_bad_n = n;
                first_got = {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun};
                first_exp = {e_bclk, e_lr, e_sd, e_fs, e_ur, e_ov};
            end
            stream_err++;
        end
        if (underrun === 1'b1) dut_ur_cnt++;
        if (overrun === 1'b1) dut_ov_cnt++;
    endtask

    // Collect one frame as sampled on 64 BCLK rises, optionally pulsing samples mid-frame.
    task automatic capture_frame(input bit started, input int n_inj,
                                 input logic [31:0] s1, input logic [31:0] s2,
                                 output logic [63:0] sd, output logic [63:0] lr,
                                 output logic ur0, output bit ok);
        int guard, rises;
        logic pb;
        ok = 1; sd = '0; lr = '0; ur0 = underrun; guard = 0;
        if (!started) begin
            do begin
                tick(); guard++;
            end while (frame_start !== 1'b1 && guard < 2 * FRAME);
            if (frame_start !== 1'b1) ok = 0;
            ur0 = underrun;
        end
        rises = 0; guard = 0; pb = i2s_bclk;
        while (rises < 64 && guard < 2 * FRAME) begin
            if ((n_inj >= 1 && guard == 40) || (n_inj >= 2 && guard == 200)) begin
                bus.audio_in = (guard == 40) ? s1 : s2;
                bus.sample_en = 1'b1;
            end
            tick();
            bus.sample_en = 1'b0;
            guard++;
            if (i2s_bclk === 1'b1 && pb === 1'b0) begin
                sd = {sd[62:0], i2s_sdata};
                lr = {lr[62:0], i2s_lrclk};
                rises++;
            end
            pb = i2s_bclk;
        end
        if (rises < 64) ok = 0;
    endtask

    task automatic release_timing(output int rise_c, output int fs_c, output logic ur_fs);
        rise_c = -1; fs_c = -1; ur_fs = 1'b0;
        reset_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (rise_c < 0 && i2s_bclk === 1'b1) rise_c = c;
            if (fs_c < 0 && frame_start === 1'b1) begin
                fs_c = c;
                ur_fs = underrun;
            end
        end
    endtask

    task automatic test_reset();
        int rc, fc;
        logic ur;
        stream_err = 0;
        reset_n = 1'b0; bus.sample_en = 1'b0; bus.audio_in = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle=%0d got=%b expected=000000", i,
                         {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun});
            end
        end
        release_timing(rc, fc, ur);
        vectors++;
        if (rc !== DIV) begin miscompares++; $display("FAIL reset_first_rise got=%0d expected=%0d", rc, DIV); end
        vectors++;
        if (fc !== 2 * DIV) begin miscompares++; $display("FAIL reset_first_load got=%0d expected=%0d", fc, 2 * DIV); end
        vectors++;
        if (ur !== 1'b1) begin miscompares++; $display("FAIL reset_first_underrun got=%b expected=1", ur); end
        vectors++;
        if (stream_err !== 0) begin
            miscompares++;
            $display("FAIL reset_stream errors=%0d n=%0d got=%b expected=%b", stream_err, first_bad_n, first_got, first_exp);
        end
        $display("test_reset: first rise %0d, first load %0d, underrun %b", rc, fc, ur);
    endtask

    task automatic test_basic_frame();
        logic [63:0] sd, lr;
        logic ur0;
        bit ok;
        stream_err = 0;
        bus.audio_in = {16'h8001, 16'hA5C3};
        bus.sample_en = 1'b1;
        tick();
        bus.sample_en = 1'b0;
        capture_frame(0, 0, '0, '0, sd, lr, ur0, ok);
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_timeout got=%b expected=1", ok); end
        vectors++;
        if (sd !== exp_frame(16'hA5C3, 16'h8001)) begin
            miscompares++; $display("FAIL basic_sdata got=%h expected=%h", sd, exp_frame(16'hA5C3, 16'h8001));
        end
        vectors++;
        if (lr !== LR_EXP) begin miscompares++; $display("FAIL basic_lrclk got=%h expected=%h", lr, LR_EXP); end
        vectors++;
        if (ur0 !== 1'b0) begin miscompares++; $display("FAIL basic_underrun got=%b expected=0", ur0); end
        vectors++;
        if (stream_err !== 0) begin
            miscompares++;
            $display("FAIL basic_stream errors=%0d n=%0d got=%b expected=%b", stream_err, first_bad_n, first_got, first_exp);
        end
        $display("test_basic_frame: sdata %h lrclk %h", sd, lr);
    endtask

    task automatic test_underrun_repeat();
        logic [63:0] sd, lr;
        logic ur0;
        bit ok;
        int u0;
        stream_err = 0;
        u0 = dut_ur_cnt;
        capture_frame(0, 0, '0, '0, sd, lr, ur0, ok);
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL underrun_timeout got=%b expected=1", ok); end
        vectors++;
        if (sd !== exp_frame(16'hA5C3, 16'h8001)) begin
            miscompares++; $display("FAIL underrun_sdata got=%h expected=%h", sd, exp_frame(16'hA5C3, 16'h8001));
        end
        vectors++;
        if (ur0 !== 1'b1) begin miscompares++; $display("FAIL underrun_at_load got=%b expected=1", ur0); end
        vectors++;
        if (dut_ur_cnt - u0 !== 1) begin miscompares++; $display("FAIL underrun_pulses got=%0d expected=1", dut_ur_cnt - u0); end
        vectors++;
        if (stream_err !== 0) begin
            miscompares++;
            $display("FAIL underrun_stream errors=%0d n=%0d got=%b expected=%b", stream_err, first_bad_n, first_got, first_exp);
        end
        $display("test_underrun_repeat: sdata %h underrun pulses %0d", sd, dut_ur_cnt - u0);
    endtask

    task automatic test_overrun();
        logic [63:0] sd, lr;
        logic ur0;
        bit ok;
        int o0;
        stream_err = 0;
        o0 = dut_ov_cnt;
        capture_frame(0, 2, {2{16'h1111}}, {2{16'h2222}}, sd, lr, ur0, ok);
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL overrun_timeout1 got=%b expected=1", ok); end
        vectors++;
        if (sd !== exp_frame(16'hA5C3, 16'h8001)) begin
            miscompares++; $display("FAIL overrun_active_frame got=%h expected=%h", sd, exp_frame(16'hA5C3, 16'h8001));
        end
        vectors++;
        if (dut_ov_cnt - o0 !== 1) begin miscompares++; $display("FAIL overrun_pulses got=%0d expected=1", dut_ov_cnt - o0); end
        capture_frame(0, 0, '0, '0, sd, lr, ur0, ok);
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL overrun_timeout2 got=%b expected=1", ok); end
        vectors++;
        if (sd !== exp_frame(16'h2222, 16'h2222)) begin
            miscompares++; $display("FAIL overrun_next_frame got=%h expected=%h", sd, exp_frame(16'h2222, 16'h2222));
        end
        vectors++;
        if (ur0 !== 1'b0) begin miscompares++; $display("FAIL overrun_next_underrun got=%b expected=0", ur0); end
        vectors++;
        if (stream_err !== 0) begin
            miscompares++;
            $display("FAIL overrun_stream errors=%0d n=%0d got=%b expected=%b", stream_err, first_bad_n, first_got, first_exp);
        end
        $display("test_overrun: next frame %h overrun pulses %0d", sd, dut_ov_cnt - o0);
    endtask

    task automatic test_coincident_load();
        logic [63:0] sd, lr;
        logic ur0, fs_seen, ur_seen;
        bit ok;
        int o0, g;
        stream_err = 0;
        o0 = dut_ov_cnt;
        g = 0;
        while ((n + 1) % FRAME != 2 * DIV && g < 2 * FRAME) begin
            tick(); g++;
        end
        bus.audio_in = {16'hFFFF, 16'h7FFF};
        bus.sample_en = 1'b1;
        tick();
        bus.sample_en = 1'b0;
        fs_seen = frame_start;
        ur_seen = underrun;
        vectors++;
        if (fs_seen !== 1'b1) begin miscompares++; $display("FAIL coincident_frame_start got=%b expected=1", fs_seen); end
        vectors++;
        if (ur_seen !== 1'b0) begin miscompares++; $display("FAIL coincident_underrun got=%b expected=0", ur_seen); end
        capture_frame(1, 0, '0, '0, sd, lr, ur0, ok);
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL coincident_timeout got=%b expected=1", ok); end
        vectors++;
        if (sd !== exp_frame(16'h7FFF, 16'hFFFF)) begin
            miscompares++; $display("FAIL coincident_sdata got=%h expected=%h", sd, exp_frame(16'h7FFF, 16'hFFFF));
        end
        vectors++;
        if (dut_ov_cnt - o0 !== 0) begin miscompares++; $display("FAIL coincident_overrun got=%0d expected=0", dut_ov_cnt - o0); end
        vectors++;
        if (stream_err !== 0) begin
            miscompares++;
            $display("FAIL coincident_stream errors=%0d n=%0d got=%b expected=%b", stream_err, first_bad_n, first_got, first_exp);
        end
        $display("test_coincident_load: sdata %h", sd);
    endtask

    task automatic test_reset_mid_frame();
        int rc, fc, g;
        logic ur;
        stream_err = 0;
        g = 0;
        while (n % FRAME != 40 && g < 2 * FRAME) begin tick(); g++; end
        bus.audio_in = {16'h5678, 16'h1234};
        bus.sample_en = 1'b1;
        tick();
        bus.sample_en = 1'b0;
        g = 0;
        while (n % FRAME != 84 && g < 2 * FRAME) begin tick(); g++; end
        reset_n = 1'b0;
        tick();
        vectors++;
        if ({i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun} !== 6'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs got=%b expected=000000",
                     {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun});
        end
        repeat (3) tick();
        release_timing(rc, fc, ur);
        vectors++;
        if (rc !== DIV) begin miscompares++; $display("FAIL midreset_first_rise got=%0d expected=%0d", rc, DIV); end
        vectors++;
        if (fc !== 2 * DIV) begin miscompares++; $display("FAIL midreset_first_load got=%0d expected=%0d", fc, 2 * DIV); end
        vectors++;
        if (ur !== 1'b1) begin miscompares++; $display("FAIL midreset_underrun got=%b expected=1", ur); end
        vectors++;
        if (stream_err !== 0) begin
            miscompares++;
            $display("FAIL midreset_stream errors=%0d n=%0d got=%b expected=%b", stream_err, first_bad_n, first_got, first_exp);
        end
        $display("test_reset_mid_frame: first rise %0d, first load %0d, underrun %b", rc, fc, ur);
    endtask

    task automatic test_random_stream();
        int u_dut, o_dut, u_mod, o_mod;
        stream_err = 0;
        u_dut = dut_ur_cnt; o_dut = dut_ov_cnt; u_mod = m_ur_cnt; o_mod = m_ov_cnt;
        for (int i = 0; i < 8 * FRAME; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                bus.audio_in = $urandom;
                bus.sample_en = 1'b1;
            end
            tick();
            bus.sample_en = 1'b0;
        end
        vectors++;
        if (stream_err !== 0) begin
            miscompares++;
            $display("FAIL random_stream errors=%0d n=%0d got=%b expected=%b", stream_err, first_bad_n, first_got, first_exp);
        end
        vectors++;
        if (dut_ur_cnt - u_dut !== m_ur_cnt - u_mod) begin
            miscompares++; $display("FAIL random_underrun_count got=%0d expected=%0d", dut_ur_cnt - u_dut, m_ur_cnt - u_mod);
        end
        vectors++;
        if (dut_ov_cnt - o_dut !== m_ov_cnt - o_mod) begin
            miscompares++; $display("FAIL random_overrun_count got=%0d expected=%0d", dut_ov_cnt - o_dut, m_ov_cnt - o_mod);
        end
        $display("test_random_stream: underruns %0d overruns %0d", m_ur_cnt - u_mod, m_ov_cnt - o_mod);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_ur_cnt = 0; m_ov_cnt = 0; dut_ur_cnt = 0; dut_ov_cnt = 0;
        stream_err = 0; first_bad_n = 0; first_got = '0; first_exp = '0;
        n = 0; m_full = 0; m_frame = '0; m_pend = '0;
        bus.sample_en = 1'b0;
        bus.audio_in = '0;
        test_reset();
        test_basic_frame();
        test_underrun_repeat();
        test_overrun();
        test_coincident_load();
        test_reset_mid_frame();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Stereo I2S transmitter at the output end of the FX chain. It accepts the same stereo sample bus and `sample_en` strobe that the FX blocks use, buffers one sample pair, and serializes it MSB-first as a Philips I2S stream (BCLK, LRCLK, SDATA) toward the DAC. BCLK is derived from `clk` by an internal divider. Underrun and overrun are flagged with one-cycle pulses.

## Interface
- `DATA_W`, default 16: sample width per channel, two's complement.
- `SLOT_W`, default 32: BCLK periods per channel slot. Must satisfy SLOT_W >= DATA_W+1.
- `BCLK_DIV`, default 4: `clk` cycles per BCLK half-period. Must be >= 1.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `audio_in` in [1:0][DATA_W-1:0]: [0] = left, [1] = right.
- `sample_en` in 1: one-cycle strobe marking `audio_in` as valid.
- `i2s_bclk` out 1: bit clock.
- `i2s_lrclk` out 1: 0 = left slot, 1 = right slot.
- `i2s_sdata` out 1: serial data.
- `frame_start` out 1: one-cycle pulse when a new frame is loaded.
- `underrun` out 1: one-cycle pulse when a frame is loaded with no new sample; the previous sample repeats.
- `overrun` out 1: one-cycle pulse when `sample_en` arrives while the pending buffer is still full.

## Operation
- **Reset values:** all outputs are 0. `div_cnt`=0. `bit_idx`=2*SLOT_W-1. The pending buffer is empty. Pending and frame registers are 0.
- **Divider:**
  - `div_cnt` counts 0..BCLK_DIV-1. At BCLK_DIV-1 it wraps and `i2s_bclk` toggles.
  - A 1->0 toggle is a "fall event" and is the only instant any serial state advances.
- **On each fall event:**
  - `bit_idx` increments modulo 2*SLOT_W.
  - `i2s_lrclk` = (new `bit_idx` >= SLOT_W).
- **SDATA mapping:** let p = `bit_idx` mod SLOT_W and ch = `i2s_lrclk`.
  - p=0: `i2s_sdata` = 0 (the one-BCLK I2S delay).
  - p=1..DATA_W: `i2s_sdata` = frame[ch][DATA_W-p].
  - p>DATA_W: `i2s_sdata` = 0.
- **Frame load:** occurs on the fall event where `bit_idx` wraps to 0.
  - If `sample_en` is high the same cycle, `audio_in` loads directly into frame (bypass). Pending stays/becomes empty. No underrun.
  - Else if pending is full, pending loads into frame and pending becomes empty.
  - Else frame is unchanged and `underrun` pulses.
  - `frame_start` pulses on every load.
- **Capture outside a load cycle:** `sample_en` writes `audio_in` into pending and sets it full.
  - If pending was already full, the new sample overwrites it and `overrun` pulses.
- **Parameter rule:** the TX does not check DATA_W/SLOT_W legality at runtime. Illegal parameter values are a configuration error, caught by an elaboration assertion.
- **Mid-operation reset:** a reset at any point restores all reset values at the next edge. Any partial frame is abandoned; there is no flush.

## Timing
- BCLK period = 2*BCLK_DIV `clk` cycles. Frame length = 2*SLOT_W BCLK periods = 4*SLOT_W*BCLK_DIV `clk` cycles.
- After reset release:
  - First rising BCLK edge: on cycle BCLK_DIV.
  - First fall event, which is also the first frame load: cycle 2*BCLK_DIV.
- `i2s_lrclk` and `i2s_sdata` are registered and change only on the cycle of a fall event, so they are stable across the rising BCLK edge.
- Latency from `sample_en` to the MSB on `i2s_sdata`:
  - The sample is loaded at the next frame load, or at a coincident one.
  - The left MSB appears 1 BCLK period after that load.
  - The right MSB appears SLOT_W+1 BCLK periods after that load.
- `frame_start`, `underrun` and `overrun` are registered, asserted the cycle after the triggering event, and high for exactly 1 cycle.
- `sample_en` is assumed to arrive at most once per frame in normal operation. Faster input produces `overrun` without corruption of the active frame.

## Test plan
1. **Reset:** hold `reset_n`=0 for 5 cycles with BCLK_DIV=2.
   - All outputs 0.
   - Release; first `i2s_bclk` rise at cycle 2, first fall and `frame_start` at cycle 4.
   - `underrun`=1 on that first load, since no sample has been supplied.
2. **Basic frame:** DATA_W=16, SLOT_W=32. Pulse `sample_en` with left=16'hA5C3, right=16'h8001 before a frame load.
   - Sample SDATA on BCLK rises.
   - Left slot: bit0=0, then A5C3 MSB-first, then 15 zeros.
   - Right slot: bit0=0, then 8001, then 15 zeros.
   - LRCLK low for 32 BCLKs, then high for 32.
3. **Underrun repeat:** supply no new sample for the second frame.
   - The same A5C3/8001 bits repeat.
   - `underrun` pulses once at that frame's load.
4. **Overrun:** two `sample_en` pulses in one frame, 16'h1111 then 16'h2222 on both channels.
   - `overrun` pulses once.
   - The next frame transmits 2222/2222.
   - The active frame is unaltered.
5. **Coincident load:** assert `sample_en` (16'h7FFF/16'hFFFF) exactly on the wrap fall event.
   - That frame transmits 7FFF/FFFF.
   - No underrun or overrun.
6. **Reset mid-frame:** drive `reset_n`=0 at `bit_idx`=20.
   - Outputs return to 0 next cycle.
   - After release, the timing from scenario 1 repeats exactly.
